// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream: streaming KxK multi-channel convolution engine.
//
// Accepts a raster-order pixel stream (CH unsigned channels per pixel, channel 0 in
// the LSBs), keeps K-1 line buffers plus a KxK x CH window, and emits one signed
// sum of KxK x CH products per fired window position (stride 1 or 2).
// Pipeline: column capture -> window -> products -> adder/output register.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   img_width, img_height      frame geometry, static during a frame
//   stride                     2 selects stride 2, anything else is stride 1
//   w_we, w_addr, w_data       weight write port, index ch*K*K + r*K + c
//   in_valid/in_ready/in_pixel input stream
//   out_valid/out_ready        output handshake
//   out_pixel, out_last        signed result, last result of the frame
//
// Optional feature: define CONV_RELU_EN to clamp negative sums to zero.

module conv_kxk_stream #(
    parameter int unsigned K         = 3,
    parameter int unsigned CH        = 1,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned W_W       = 8,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned MAX_WIDTH = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             img_width,
    input  logic [15:0]             img_height,
    input  logic [1:0]              stride,
    input  logic                    w_we,
    input  logic [7:0]              w_addr,
    input  logic signed [W_W-1:0]   w_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH*DATA_W-1:0]    in_pixel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_pixel,
    output logic                    out_last
);

    localparam int unsigned PXW = CH * DATA_W;
    localparam int unsigned NT  = K * K * CH;
    localparam int unsigned PW  = DATA_W + W_W + 1;
    localparam int unsigned AW  = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    logic          en, accept, fire, last_pos, stride2, col_end, row_end;
    logic [15:0]   row, col;
    logic          row_ph, col_ph;
    logic [AW-1:0] lb_addr;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign stride2  = (stride == 2'd2);
    assign col_end  = (col == img_width - 16'd1);
    assign row_end  = (row == img_height - 16'd1);
    assign lb_addr  = col[AW-1:0];

    // Phase bits are 0 on fired rows/columns when striding by 2.
    assign fire = accept && (row >= 16'(K - 1)) && (col >= 16'(K - 1)) &&
                  (!stride2 || (!row_ph && !col_ph));

    // Last fired position: no further fire fits in either direction.
    assign last_pos = (({1'b0, row} + (stride2 ? 17'd2 : 17'd1)) >= {1'b0, img_height}) &&
                      (({1'b0, col} + (stride2 ? 17'd2 : 17'd1)) >= {1'b0, img_width});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row    <= '0;
            col    <= '0;
            row_ph <= 1'b0;
            col_ph <= 1'b0;
        end else if (accept) begin
            if (col_end) begin
                col    <= '0;
                col_ph <= 1'b0;
                if (row_end) begin
                    row    <= '0;
                    row_ph <= 1'b0;
                end else begin
                    row    <= row + 16'd1;
                    row_ph <= (row >= 16'(K - 1)) ? ~row_ph : 1'b0;
                end
            end else begin
                col    <= col + 16'd1;
                col_ph <= (col >= 16'(K - 1)) ? ~col_ph : 1'b0;
            end
        end
    end

    // Line buffers: row 0 holds the oldest line; each accept moves a column up one line.
    logic [(K-1)*PXW-1:0] lb_rd;

    for (genvar r = 0; r < K - 1; r++) begin : g_lb
        logic [PXW-1:0] mem [MAX_WIDTH];
        logic [PXW-1:0] wr;
        if (r == K - 2) begin : g_top
            assign wr = in_pixel;
        end else begin : g_mid
            assign wr = lb_rd[(r+1)*PXW +: PXW];
        end
        assign lb_rd[r*PXW +: PXW] = mem[lb_addr];
        always_ff @(posedge clk) begin
            if (accept) mem[lb_addr] <= wr;
        end
    end

    // Pipeline valids: stage 0 column capture, stage 1 window, stage 2 products.
    logic a0, f0, l0, v1, l1, v2, l2;

    logic [K*PXW-1:0]   col_q;
    logic [K*K*PXW-1:0] win_q, win_d;
    logic [NT*PW-1:0]   prod_d, prod_q;
    logic [NT*W_W-1:0]  wts;

    // Window slot (r, c) sits at (r*K + c)*PXW; column K-1 is the newest.
    for (genvar r = 0; r < K; r++) begin : g_wr
        for (genvar c = 0; c < K; c++) begin : g_wc
            if (c < K - 1) begin : g_shift
                assign win_d[(r*K+c)*PXW +: PXW] = win_q[(r*K+c+1)*PXW +: PXW];
            end else begin : g_new
                assign win_d[(r*K+c)*PXW +: PXW] = col_q[r*PXW +: PXW];
            end
        end
    end

    for (genvar i = 0; i < NT; i++) begin : g_w
        logic signed [W_W-1:0] w_q;
        always_ff @(posedge clk) begin
            if (!rst_n) w_q <= '0;
            else if (w_we && (w_addr == 8'(i))) w_q <= w_data;
        end
        assign wts[i*W_W +: W_W] = w_q;
    end

    for (genvar ch = 0; ch < CH; ch++) begin : g_mch
        for (genvar r = 0; r < K; r++) begin : g_mr
            for (genvar c = 0; c < K; c++) begin : g_mc
                localparam int unsigned Idx = ch*K*K + r*K + c;
                logic [DATA_W-1:0]    px;
                logic [W_W-1:0]       wt;
                logic signed [PW-1:0] a, b;
                assign px = win_q[(r*K+c)*PXW + ch*DATA_W +: DATA_W];
                assign wt = wts[Idx*W_W +: W_W];
                assign a  = {{(PW-DATA_W){1'b0}}, px};
                assign b  = {{(PW-W_W){wt[W_W-1]}}, wt};
                assign prod_d[Idx*PW +: PW] = a * b;
            end
        end
    end

    // Sign-extend each product and accumulate; wraps modulo 2^ACC_W.
    logic [(NT+1)*ACC_W-1:0] psum;
    logic [ACC_W-1:0]        sum, result;

    assign psum[ACC_W-1:0] = '0;
    for (genvar i = 0; i < NT; i++) begin : g_sum
        assign psum[(i+1)*ACC_W +: ACC_W] = psum[i*ACC_W +: ACC_W] +
            {{(ACC_W-PW){prod_q[i*PW+PW-1]}}, prod_q[i*PW +: PW]};
    end
    assign sum = psum[NT*ACC_W +: ACC_W];

`ifdef CONV_RELU_EN
    assign result = sum[ACC_W-1] ? '0 : sum;
`else
    assign result = sum;
`endif

    // Datapath registers need no reset; their valids gate everything downstream.
    always_ff @(posedge clk) begin
        if (en) begin
            if (accept) col_q <= {in_pixel, lb_rd};
            if (a0) win_q <= win_d;
            prod_q <= prod_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a0        <= 1'b0;
            f0        <= 1'b0;
            l0        <= 1'b0;
            v1        <= 1'b0;
            l1        <= 1'b0;
            v2        <= 1'b0;
            l2        <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_pixel <= '0;
        end else if (en) begin
            a0        <= accept;
            f0        <= fire;
            l0        <= fire && last_pos;
            v1        <= f0;
            l1        <= l0;
            v2        <= v1;
            l2        <= l1;
            out_valid <= v2;
            out_last  <= v2 && l2;
            if (v2) out_pixel <= result;
        end
    end

endmodule

// File: tb/tb_conv_kxk_stream.sv
module tb_conv_kxk_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] img_width, img_height;
    logic [1:0]  stride;
    logic        w_we;
    logic [7:0]  w_addr;
    logic [7:0]  w_data;
    logic        in_valid, in_ready;
    logic [15:0] in_pixel;
    logic        out_valid, out_ready, out_last;
    logic [23:0] out_pixel;

    conv_kxk_stream #(
        .K(3), .CH(2), .DATA_W(8), .W_W(8), .ACC_W(24), .MAX_WIDTH(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .img_width(img_width), .img_height(img_height),
        .stride(stride), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [23:0] exp_q[$];
    logic        exp_last_q[$];
    int tw[18];
    int px0[64], px1[64];
    bit rnd_gap = 0, rnd_ready = 0, bp_arm = 0, lat_arm = 0, stalled = 0;
    int hold_low = 0, lat_acc = 0, lat_ov = -1;
    logic [23:0] held_px;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (hold_low > 0) begin
            out_ready = 1'b0;
            hold_low--;
        end else begin
            out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Handshakes complete at the next rising edge; inputs only change just after it.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (out_valid && stalled) check("hold_pixel", out_pixel, held_px);
            if (out_valid && !out_ready) begin
                check("in_ready_stall", in_ready, 0);
                held_px = out_pixel;
            end
            stalled = out_valid && !out_ready;
            if (lat_arm && out_valid && lat_ov < 0) lat_ov = cyc;
            if (bp_arm && out_valid) begin
                hold_low = 5;
                bp_arm = 0;
            end
            if (out_valid && out_ready) begin
                check("out_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("out_pixel", out_pixel, exp_q.pop_front());
                    check("out_last", out_last, exp_last_q.pop_front());
                end
            end
        end
    end

    task automatic push(input logic [15:0] p, input int idx);
        bit acc = 0;
        int guard = 0;
        in_valid = 1'b1;
        in_pixel = p;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("in_ready_timeout", in_ready, 1);
        if (lat_arm && idx == 10) lat_acc = cyc;
        in_valid = 1'b0;
        if (rnd_gap) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) push({8'(px1[i]), 8'(px0[i])}, i);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() > 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain", exp_q.size(), 0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic load_w();
        for (int i = 0; i < 18; i++) begin
            w_we = 1'b1; w_addr = 8'(i); w_data = 8'(tw[i]);
            @(posedge clk); #1;
        end
        w_addr = 8'd18; w_data = 8'h7f; @(posedge clk); #1;
        w_addr = 8'd255; @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic cfg(input int w, input int h, input int s);
        img_width = 16'(w); img_height = 16'(h); stride = 2'(s);
    endtask

    task automatic set_w(input int w0, input int w1);
        for (int i = 0; i < 9; i++) begin
            tw[i] = w0; tw[9+i] = w1;
        end
    endtask

    task automatic ramp_px();
        for (int i = 0; i < 64; i++) begin
            px0[i] = i; px1[i] = int'($urandom_range(0, 255));
        end
    endtask

    task automatic push_exp(input logic [23:0] v, input logic l);
        exp_q.push_back(v);
        exp_last_q.push_back(l);
    endtask

    // Reference: direct sum over every stride-aligned KxK window of the stored frame.
    task automatic expect_frame(input int w, input int h, input int s);
        for (int r = 2; r < h; r += s) begin
            for (int c = 2; c < w; c += s) begin
                int sum = 0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        int p = (r - 2 + i) * w + (c - 2 + j);
                        sum += px0[p] * tw[i*3+j] + px1[p] * tw[9+i*3+j];
                    end
                end
`ifdef CONV_RELU_EN
                if (sum < 0) sum = 0;
`endif
                push_exp(24'(sum), (r + s >= h) && (c + s >= w));
            end
        end
    endtask

    task automatic mid_reset(input int n);
        send(n);
        rst_n = 1'b0;
        exp_q.delete();
        exp_last_q.delete();
        set_w(0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pixel", out_pixel, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0; w_we = 1'b0; w_addr = '0;
        w_data = '0; out_ready = 1'b1;
        cfg(4, 4, 1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_pixel", out_pixel, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);

        // 4x4 ramp, all-ones kernel, plus first-output latency.
        set_w(1, 0); load_w(); ramp_px();
        push_exp(24'd45, 0); push_exp(24'd54, 0); push_exp(24'd81, 0); push_exp(24'd90, 1);
        lat_ov = -1; lat_arm = 1;
        send(16);
        drain();
        lat_arm = 0;
        check("latency", 32'(lat_ov - lat_acc), 3);

        // Stride 2 on 5x5.
        cfg(5, 5, 2); ramp_px();
        push_exp(24'd54, 0); push_exp(24'd72, 0); push_exp(24'd144, 0); push_exp(24'd162, 1);
        send(25);
        drain();

        // Signed single tap.
        cfg(3, 3, 1); set_w(0, 0); tw[0] = -128; load_w();
        for (int i = 0; i < 9; i++) begin
            px0[i] = 0; px1[i] = int'($urandom_range(0, 255));
        end
        px0[0] = 255;
`ifdef CONV_RELU_EN
        push_exp(24'h000000, 1);
`else
        push_exp(24'hFF8080, 1);
`endif
        send(9);
        drain();

        // Two channels with identical data.
        cfg(4, 4, 1); set_w(-1, 1); load_w();
        for (int i = 0; i < 16; i++) begin
            px0[i] = int'($urandom_range(0, 255)); px1[i] = px0[i];
        end
        expect_frame(4, 4, 1);
        send(16);
        drain();
        set_w(1, -2); load_w();
        expect_frame(4, 4, 1);
        send(16);
        drain();

        // Output backpressure for 5 cycles while results are queued.
        set_w(1, 0); load_w(); ramp_px();
        push_exp(24'd45, 0); push_exp(24'd54, 0); push_exp(24'd81, 0); push_exp(24'd90, 1);
        bp_arm = 1;
        send(16);
        drain();

        // Reset mid-frame: weights cleared, then reloaded.
        mid_reset(7);
        ramp_px();
        expect_frame(4, 4, 1);
        send(16);
        drain();
        set_w(1, 0); load_w();
        mid_reset(11);
        set_w(1, 0); load_w(); ramp_px();
        push_exp(24'd45, 0); push_exp(24'd54, 0); push_exp(24'd81, 0); push_exp(24'd90, 1);
        send(16);
        drain();

        // Randomized frames, stalls and gaps.
        rnd_gap = 1; rnd_ready = 1;
        for (int t = 0; t < 25; t++) begin
            int w = int'($urandom_range(2, 8));
            int h = int'($urandom_range(2, 8));
            int s = int'($urandom_range(0, 3));
            cfg(w, h, s);
            for (int i = 0; i < 18; i++) tw[i] = int'($signed(8'($urandom_range(0, 255))));
            load_w();
            for (int i = 0; i < 64; i++) begin
                px0[i] = int'($urandom_range(0, 255)); px1[i] = int'($urandom_range(0, 255));
            end
            expect_frame(w, h, (s == 2) ? 2 : 1);
            send(w * h);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_kxk_stream.md
Name: conv_kxk_stream

Overview:
- Parametrised streaming KxK multi-channel convolution engine, successor to the fixed 3x3 single-channel line-buffer convolver in the first-layer datapath.
- Accepts a raster-order pixel stream carrying CH channels per pixel. Sums KxK x CH signed products per output position.
- Supports stride 1/2, runtime weight loading and valid/ready backpressure on both sides.
- Sits between the pixel source (DMA/test stream) and the activation/requant stage.

Parameters:
- K, 3: kernel edge; legal 3 or 5.
- CH, 1: input channels per pixel; 1..4.
- DATA_W, 8: unsigned pixel width.
- W_W, 8: signed weight width.
- ACC_W, 24: signed accumulator/output width.
- MAX_WIDTH, 1024: max image width; line buffer depth.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- img_width  in  16  pixels per row; static during a frame.
- img_height  in  16  rows per frame; static during a frame.
- stride  in  2  1 or 2; any other value is treated as 1.
- w_we  in  1  weight write strobe.
- w_addr  in  8  weight index = ch*K*K + r*K + c; out-of-range writes are ignored.
- w_data  in  W_W  signed weight value.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_pixel  in  CH*DATA_W  channel 0 in LSBs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_pixel  out  ACC_W  signed convolution result.
- out_last  out  1  marks the final output of a frame.

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_last=0, out_pixel=0, row/col/phase counters=0, all weights=0, pipeline valids=0. Line buffer contents are not cleared. in_ready=1 the first cycle after reset.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. When en=0, every pipeline stage, window and counter holds, and out_pixel/out_last stay stable.
- Line buffers: K-1 rows x MAX_WIDTH x CH. A KxK x CH window shift register receives the new column (K-1 buffered rows plus in_pixel) on each accept.
- Counters:
  - col increments per accept.
  - At col==img_width-1: col<=0, row++.
  - At row==img_height-1 && col==img_width-1: row<=0 and col<=0, so a new frame starts automatically.
- Window fire: accept && row>=K-1 && col>=K-1 && ((row-(K-1)) mod stride==0) && ((col-(K-1)) mod stride==0). Use phase counters, not dividers.
- Latency:
  - Fire accepted at edge t, no stall: window regs valid at t+1, products registered at t+2, adder tree result at t+3 with out_valid=1.
  - Stalls add cycles 1:1.
- Arithmetic:
  - product = $signed({1'b0,pixel}) * weight, width DATA_W+W_W+1.
  - Products are sign-extended to ACC_W and summed over all K*K*CH terms.
  - Overflow wraps modulo 2^ACC_W; no saturation.
- out_last = 1 with the result whose window bottom-right is the last fired position of the frame.
- Weight writes: accepted every cycle regardless of stream state and take effect on windows entering stage 1 after the write edge. Software writes only between frames.
- Boundaries:
  - img_width<K or img_height<K: pixels are consumed and no outputs are produced.
  - img_width>MAX_WIDTH: undefined.
  - Simultaneous accept and output handshake in the same cycle: both occur, with no bubble.
  - Reset mid-frame drops all in-flight results, and the next accepted pixel is (row 0, col 0).

Optional Feature:
- CONV_RELU_EN defined: the final stage outputs max(sum,0), so negative sums become 0. Latency is unchanged.
- CONV_RELU_EN undefined: the raw signed sum is output.

Test Plan:
- K=3, CH=1, stride=1, 4x4 frame of pixels 0..15, all weights 1 -> 4 outputs 45, 54, 81, 90; out_last only on 90; first out_valid exactly 3 cycles after the accept of pixel 10 with out_ready=1.
- stride=2, 5x5 frame of pixels 0..24, weights all 1 -> outputs 54, 72, 144, 162; out_last on 162; no outputs at odd positions.
- Signed: weight index 0 = -128, others 0; pixel 255 at the top-left of the first window, rest 0 -> out_pixel = -32640 (0xFF8080 at ACC_W=24).
- CH=2: channel 0 weights all -1, channel 1 weights all +1, identical pixel data on both channels -> every output 0. With CONV_RELU_EN and channel 0 weights +1, channel 1 weights -2 -> every output 0 (without the macro: the negative sum).
- Backpressure: out_ready held low 5 cycles during the 4x4 test -> in_ready low on those cycles, out_pixel stable, the same 4 values are delivered in order with no loss or duplication.
- Reset mid-frame: assert rst_n=0 after 7 pixels of a frame, then stream a full 4x4 frame -> outputs 45, 54, 81, 90, no stale result, and weights read back as 0 (all-zero outputs) until reloaded.
